tone_pwm_gen: RTL and testbench

TONE_PWM_GEN -- requirements
Module: tone_pwm_gen

---
 rtl/tone_pwm_gen.sv | 145 ++++++++++++++
 tb/tb_tone_pwm_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_pwm_gen.sv
// Tone generator: turns a half-period count from the melody player into a
// duty-controlled square wave. A new note, a volume change or a stop only
// takes effect at the end of a period, so the buzzer never sees a runt pulse.
module tone_pwm_gen #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MIN_HALF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] frequency,
  input  logic             enable,
  input  logic [2:0]       duty,
  output logic             pwm,
  output logic             busy,
  output logic             note_start,
  output logic [15:0]      cycle_cnt
);

  // The period counter is one bit wider than the half-period so that
  // P = 2*H never overflows, even for the largest H.
  localparam int unsigned P_W    = CNT_W + 1;
  localparam int unsigned PROD_W = CNT_W + 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] w_h_nxt;
  logic [2:0]       r_d;
  logic [2:0]       w_d_nxt;
  logic [P_W-1:0]   r_cnt;
  logic [P_W-1:0]   w_cnt_nxt;
  logic [15:0]      r_cycle_cnt;
  logic [15:0]      w_cycle_cnt_nxt;
  logic             r_pwm;
  logic             w_pwm_nxt;
  logic             r_busy;
  logic             r_note_start;
  logic             w_note_start_nxt;

  logic             w_valid;
  logic [P_W-1:0]   w_period;
  logic             w_period_end;

  // High time of one period in clk cycles: (2*H*D) >> 3, truncated.
  function automatic logic [P_W-1:0] f_high_len(input logic [CNT_W-1:0] h,
                                                input logic [2:0]       d);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'({h, 1'b0}) * PROD_W'(d);
    return P_W'(prod >> 3);
  endfunction

  // A note is playable only when enabled and long enough; short or zero
  // half-periods count as silence.
  assign w_valid      = enable && (frequency != '0) &&
                        (frequency >= CNT_W'(MIN_HALF));
  assign w_period     = {r_h, 1'b0};
  assign w_period_end = (r_cnt == (w_period - P_W'(1)));

  // Next-state, latched-note and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_h_nxt          = r_h;
    w_d_nxt          = r_d;
    w_cnt_nxt        = r_cnt;
    w_cycle_cnt_nxt  = r_cycle_cnt;
    w_note_start_nxt = 1'b0;
    w_pwm_nxt        = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_valid) begin
          w_state_nxt      = PLAY;
          w_h_nxt          = frequency;
          w_d_nxt          = duty;
          w_cycle_cnt_nxt  = '0;
          w_note_start_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (!w_period_end) begin
          w_cnt_nxt = r_cnt + P_W'(1);
        end else if (!w_valid) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (frequency != r_h) begin
          w_h_nxt          = frequency;
          w_d_nxt          = duty;
          w_cnt_nxt        = '0;
          w_cycle_cnt_nxt  = '0;
          w_note_start_nxt = 1'b1;
        end else begin
          w_d_nxt   = duty;
          w_cnt_nxt = '0;
          if (r_cycle_cnt != 16'hFFFF) begin
            w_cycle_cnt_nxt = r_cycle_cnt + 16'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // pwm is registered against the counter value it will accompany.
    if (w_state_nxt == PLAY) begin
      w_pwm_nxt = (w_cnt_nxt < f_high_len(w_h_nxt, w_d_nxt));
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_h          <= '0;
      r_d          <= '0;
      r_cnt        <= '0;
      r_cycle_cnt  <= '0;
      r_pwm        <= 1'b0;
      r_busy       <= 1'b0;
      r_note_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_h          <= w_h_nxt;
      r_d          <= w_d_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cycle_cnt  <= w_cycle_cnt_nxt;
      r_pwm        <= w_pwm_nxt;
      r_busy       <= (w_state_nxt == PLAY);
      r_note_start <= w_note_start_nxt;
    end
  end

  assign pwm        = r_pwm;
  assign busy       = r_busy;
  assign note_start = r_note_start;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// Bench for tone_pwm_gen: a behavioural reference pushes expected outputs
// every clock, a checker pops them each cycle; segment tables and short
// directed sequences add hand-derived checkpoints.
module tb_tone_pwm_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] frequency;
  logic        enable;
  logic [2:0]  duty;
  logic        pwm;
  logic        busy;
  logic        note_start;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit preload_en = 1'b0;

  always #5 clk = ~clk;

  tone_pwm_gen #(.CNT_W(32), .MIN_HALF(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .frequency  (frequency),
    .enable     (enable),
    .duty       (duty),
    .pwm        (pwm),
    .busy       (busy),
    .note_start (note_start),
    .cycle_cnt  (cycle_cnt)
  );

  typedef struct packed {
    logic        pwm;
    logic        busy;
    logic        ns;
    logic [15:0] cyc;
  } out_t;

  out_t sb_q[$];

  // Reference model of the tone generator, evaluated at every rising edge.
  bit     m_play = 1'b0;
  longint m_cnt  = 0;
  longint m_h    = 0;
  longint m_d    = 0;
  int     m_cyc  = 0;
  bit     m_ns   = 1'b0;
  bit     m_pwm  = 1'b0;

  always @(posedge clk) begin
    bit     v;
    out_t   e;
    longint per;
    v = enable && (frequency >= 32'd2);
    if (!reset) begin
      m_play = 1'b0; m_cnt = 0; m_h = 0; m_d = 0; m_cyc = 0; m_ns = 1'b0;
    end else begin
      if (preload_en) m_cyc = 16'hFFFC;
      m_ns = 1'b0;
      if (!m_play) begin
        m_cnt = 0;
        if (v) begin
          m_play = 1'b1; m_h = frequency; m_d = duty; m_cyc = 0; m_ns = 1'b1;
        end
      end else begin
        per = 2 * m_h;
        if (m_cnt != per - 1) begin
          m_cnt = m_cnt + 1;
        end else if (!v) begin
          m_play = 1'b0; m_cnt = 0;
        end else if (longint'(frequency) != m_h) begin
          m_h = frequency; m_d = duty; m_cnt = 0; m_cyc = 0; m_ns = 1'b1;
        end else begin
          m_d = duty; m_cnt = 0;
          if (m_cyc < 65535) m_cyc = m_cyc + 1;
        end
      end
    end
    m_pwm = m_play && (m_cnt < (2 * m_h * m_d) / 8);
    e.pwm  = m_pwm;
    e.busy = m_play;
    e.ns   = m_ns;
    e.cyc  = 16'(m_cyc);
    sb_q.push_back(e);
  end

  // Advance one clock and compare the DUT against the scoreboard entry.
  task automatic tick();
    out_t e;
    out_t a;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t: no expected entry for this cycle", $time);
    end else begin
      e = sb_q.pop_front();
      a = {pwm, busy, note_start, cycle_cnt};
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t actual pwm=%b busy=%b ns=%b cyc=%h required pwm=%b busy=%b ns=%b cyc=%h",
                 $time, a.pwm, a.busy, a.ns, a.cyc, e.pwm, e.busy, e.ns, e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic [31:0] freq;
    logic [2:0]  duty;
    logic        en;
    int          cycles;
    logic        exp_busy;
    logic [15:0] exp_cyc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int hi;
    bool_wait: begin end
    reset = 1'b0; frequency = 32'd5; duty = 3'd4; enable = 1'b1;

    // {reset, frequency, duty, enable, cycles, busy, cycle_cnt at segment end}
    vecs[0]  = '{1'b0, 32'd5, 3'd4, 1'b1,  2, 1'b0, 16'd0}; // held in reset
    vecs[1]  = '{1'b1, 32'd5, 3'd4, 1'b1,  1, 1'b1, 16'd0}; // first edge -> PLAY
    vecs[2]  = '{1'b1, 32'd5, 3'd4, 1'b1, 30, 1'b1, 16'd3}; // 5 high / 5 low x3
    vecs[3]  = '{1'b1, 32'd4, 3'd2, 1'b1, 10, 1'b1, 16'd0}; // new note at period end
    vecs[4]  = '{1'b1, 32'd4, 3'd2, 1'b1, 16, 1'b1, 16'd2}; // 2 high / 6 low
    vecs[5]  = '{1'b1, 32'd4, 3'd0, 1'b1, 16, 1'b1, 16'd4}; // duty 0, still busy
    vecs[6]  = '{1'b1, 32'd0, 3'd0, 1'b1,  8, 1'b0, 16'd4}; // silence -> IDLE, cnt held
    vecs[7]  = '{1'b1, 32'd1, 3'd4, 1'b1,  5, 1'b0, 16'd4}; // below MIN_HALF
    vecs[8]  = '{1'b1, 32'd3, 3'd4, 1'b0,  4, 1'b0, 16'd4}; // disabled
    vecs[9]  = '{1'b1, 32'd3, 3'd7, 1'b1,  1, 1'b1, 16'd0}; // duty 7: 5 of 6 high
    vecs[10] = '{1'b1, 32'd3, 3'd7, 1'b1,  9, 1'b1, 16'd1}; // stop at cnt=3
    vecs[11] = '{1'b1, 32'd3, 3'd7, 1'b0,  3, 1'b0, 16'd1}; // enable drop mid-period
    vecs[12] = '{1'b1, 32'd2, 3'd4, 1'b1,  1, 1'b1, 16'd0}; // shortest note

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; frequency = vecs[i].freq;
      duty  = vecs[i].duty; enable   = vecs[i].en;
      repeat (vecs[i].cycles) tick();
      check($sformatf("seg%0d_busy", i), longint'(busy), longint'(vecs[i].exp_busy));
      check($sformatf("seg%0d_cycle_cnt", i), longint'(cycle_cnt), longint'(vecs[i].exp_cyc));
    end

    // Note change 5 -> 3 at cnt=3: current period completes first.
    frequency = 32'd0;
    repeat (4) tick();
    check("chg_idle_busy", longint'(busy), 0);
    frequency = 32'd5; duty = 3'd4;
    tick();
    check("chg_start_pulse", longint'(note_start), 1);
    repeat (3) tick();
    frequency = 32'd3;
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      hi += int'(pwm);
    end
    check("chg_old_period_tail_high", longint'(hi), 1);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      hi += int'(pwm);
      if (k == 0) begin
        check("chg_new_note_start", longint'(note_start), 1);
        check("chg_new_cycle_cnt", longint'(cycle_cnt), 0);
      end
    end
    check("chg_new_period_high", longint'(hi), 3);

    // Reset pulsed at cnt=4 of a 10-cycle period aborts it at once.
    frequency = 32'd5;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_restart_pulse", longint'(note_start), 1);
    repeat (4) tick();
    check("rst_pre_pwm_high", longint'(pwm), 1);
    reset = 1'b0;
    tick();
    check("rst_abort_pwm", longint'(pwm), 0);
    check("rst_abort_busy", longint'(busy), 0);
    reset = 1'b1;
    tick();
    check("rst_release_pulse", longint'(note_start), 1);
    check("rst_release_pwm", longint'(pwm), 1);
    check("rst_release_busy", longint'(busy), 1);

    // Saturation: the period count is preloaded near the top so that the
    // limit is reached in a handful of periods.
    frequency = 32'd2; duty = 3'd4;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_play && m_h == 2 && m_cnt == 0) begin
        hi = 1;
        break;
      end
    end
    check("sat_note_reached", longint'(hi), 1);
    if (hi == 1) begin
      #1;
      force dut.r_cycle_cnt = 16'hFFFC;
      preload_en = 1'b1;
      tick();
      #1;
      release dut.r_cycle_cnt;
      preload_en = 1'b0;
      repeat (20) tick();
      check("sat_cycle_cnt_hold", longint'(cycle_cnt), 65535);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
